// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment nums arbiter.
package seg_pkg;

  localparam logic [1:0]  SRC_BASE  = 2'd0;
  localparam logic [1:0]  SRC_NOTE  = 2'd1;
  localparam logic [1:0]  SRC_ALERT = 2'd2;

  localparam logic [15:0] DASH_NUMS = 16'h9999;

  typedef enum logic [1:0] {
    ST_BASE  = 2'd0,
    ST_NOTE  = 2'd1,
    ST_ALERT = 2'd2
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_CYCLES-1 counter; tick marks the last count, clr restarts the period.
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_nums_arbiter.sv
// Fixed-priority (alert > note > base) owner of the 4-digit seven-segment nums bus,
// with a timed note overlay and a blinking alert.
module seg_nums_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1000000,
  parameter int unsigned HOLD_TICKS  = 100,
  parameter int unsigned BLINK_TICKS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_nums,
  input  logic        note_req,
  input  logic [15:0] note_nums,
  input  logic        alert,
  input  logic [15:0] alert_nums,
  output logic [15:0] nums,
  output logic [1:0]  src,
  output logic        note_active
);

  localparam int unsigned TW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [TW-1:0] HOLD_VAL   = TW'(HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   note_q, note_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          alert_q;
  logic [15:0]   nums_q, nums_d;
  logic [1:0]    src_q, src_d;
  logic          note_active_q, note_active_d;
  logic          tick;
  logic          alert_rise;

  assign alert_rise = alert & ~alert_q;

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (note_req | alert_rise),
    .tick(tick)
  );

  always_comb begin
    timer_d = timer_q;
    note_d  = note_q;
    if (note_req) begin
      note_d  = note_nums;
      timer_d = HOLD_VAL;
    end else if (tick && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
  end

  // Transitions look at the post-update timer so an expiring tick is seen this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BASE: begin
        if (alert)         state_d = ST_ALERT;
        else if (note_req) state_d = ST_NOTE;
      end
      ST_NOTE: begin
        if (alert)                state_d = ST_ALERT;
        else if (timer_d == '0)   state_d = ST_BASE;
      end
      ST_ALERT: begin
        if (!alert) state_d = (timer_d != '0) ? ST_NOTE : ST_BASE;
      end
      default: state_d = ST_BASE;
    endcase
  end

  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if ((state_d == ST_ALERT) && (state_q != ST_ALERT)) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if ((state_q == ST_ALERT) && tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  // Outputs are decoded from next state so they land one cycle after the inputs.
  always_comb begin
    nums_d        = base_nums;
    src_d         = SRC_BASE;
    note_active_d = (timer_d != '0);
    unique case (state_d)
      ST_BASE: begin
        nums_d = base_nums;
        src_d  = SRC_BASE;
      end
      ST_NOTE: begin
        nums_d = note_d;
        src_d  = SRC_NOTE;
      end
      ST_ALERT: begin
        nums_d = phase_d ? DASH_NUMS : alert_nums;
        src_d  = SRC_ALERT;
      end
      default: begin
        nums_d = DASH_NUMS;
        src_d  = SRC_BASE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BASE;
      timer_q       <= '0;
      note_q        <= '0;
      blink_q       <= '0;
      phase_q       <= 1'b0;
      alert_q       <= 1'b0;
      nums_q        <= DASH_NUMS;
      src_q         <= SRC_BASE;
      note_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      note_q        <= note_d;
      blink_q       <= blink_d;
      phase_q       <= phase_d;
      alert_q       <= alert;
      nums_q        <= nums_d;
      src_q         <= src_d;
      note_active_q <= note_active_d;
    end
  end

  assign nums        = nums_q;
  assign src         = src_q;
  assign note_active = note_active_q;

endmodule

// File: tb/tb_seg_nums_arbiter.sv
// Scoreboard bench: the driver queues the hand-computed response for each cycle,
// a monitor pops and compares it after every rising edge.
module tb_seg_nums_arbiter;

  typedef struct packed {
    logic [15:0] nums;
    logic [1:0]  src;
    logic        na;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base_nums = 16'h0123;
  logic        note_req = 1'b0;
  logic [15:0] note_nums = 16'h0000;
  logic        alert = 1'b0;
  logic [15:0] alert_nums = 16'h4444;
  logic [15:0] nums;
  logic [1:0]  src;
  logic        note_active;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_idx = 0;

  seg_nums_arbiter #(
    .TICK_CYCLES(4),
    .HOLD_TICKS (3),
    .BLINK_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .base_nums  (base_nums),
    .note_req   (note_req),
    .note_nums  (note_nums),
    .alert      (alert),
    .alert_nums (alert_nums),
    .nums       (nums),
    .src        (src),
    .note_active(note_active)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (nums !== e.nums || src !== e.src || note_active !== e.na) begin
        failures++;
        $display("FAIL cycle_%0d: got nums=%h src=%0d note_active=%b, want nums=%h src=%0d note_active=%b",
                 cyc_idx, nums, src, note_active, e.nums, e.src, e.na);
      end
      cyc_idx++;
    end
  end

  task automatic chk_now(input string name, input logic [15:0] en, input logic [1:0] es,
                         input logic ena);
    checks++;
    if (nums !== en || src !== es || note_active !== ena) begin
      failures++;
      $display("FAIL %s: got nums=%h src=%0d note_active=%b, want nums=%h src=%0d note_active=%b",
               name, nums, src, note_active, en, es, ena);
    end
  endtask

  task automatic cyc(input logic a, input logic nr, input logic [15:0] nn,
                     input logic [15:0] en, input logic [1:0] es, input logic ena);
    @(negedge clk);
    alert     = a;
    note_req  = nr;
    note_nums = nn;
    exp_q.push_back('{nums: en, src: es, na: ena});
  endtask

  task automatic hold(input int n, input logic a, input logic [15:0] en, input logic [1:0] es,
                      input logic ena);
    repeat (n) cyc(a, 1'b0, 16'h0000, en, es, ena);
  endtask

  initial begin
    // Reset state, then first edge after release shows base
    #12;
    chk_now("reset_state", 16'h9999, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{nums: 16'h0123, src: 2'd0, na: 1'b0});
    hold(2, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Note hold: 12 cycles of overlay
    cyc(1'b0, 1'b1, 16'h0512, 16'h0512, 2'd1, 1'b1);
    hold(11, 1'b0, 16'h0512, 2'd1, 1'b1);
    hold(3, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Retrigger 6 cycles in: 18-cycle total overlay
    cyc(1'b0, 1'b1, 16'h0512, 16'h0512, 2'd1, 1'b1);
    hold(5, 1'b0, 16'h0512, 2'd1, 1'b1);
    cyc(1'b0, 1'b1, 16'h3400, 16'h3400, 2'd1, 1'b1);
    hold(11, 1'b0, 16'h3400, 2'd1, 1'b1);
    hold(3, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Alert blink: 8 on, 8 dashes, 8 on
    hold(8, 1'b1, 16'h4444, 2'd2, 1'b0);
    hold(8, 1'b1, 16'h9999, 2'd2, 1'b0);
    hold(8, 1'b1, 16'h4444, 2'd2, 1'b0);
    hold(2, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Short alert over a note: note resumes for its remaining 4 cycles
    cyc(1'b0, 1'b1, 16'h0512, 16'h0512, 2'd1, 1'b1);
    hold(3, 1'b0, 16'h0512, 2'd1, 1'b1);
    hold(4, 1'b1, 16'h4444, 2'd2, 1'b1);
    hold(4, 1'b0, 16'h0512, 2'd1, 1'b1);
    hold(3, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Long alert outlives the note: straight back to base
    cyc(1'b0, 1'b1, 16'h0512, 16'h0512, 2'd1, 1'b1);
    hold(3, 1'b0, 16'h0512, 2'd1, 1'b1);
    hold(8, 1'b1, 16'h4444, 2'd2, 1'b1);
    hold(8, 1'b1, 16'h9999, 2'd2, 1'b0);
    hold(3, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Alert rising together with note_req: note shows after the alert
    cyc(1'b1, 1'b1, 16'h0777, 16'h4444, 2'd2, 1'b1);
    hold(2, 1'b1, 16'h4444, 2'd2, 1'b1);
    hold(9, 1'b0, 16'h0777, 1'b1 ? 2'd1 : 2'd1, 1'b1);
    hold(2, 1'b0, 16'h0123, 2'd0, 1'b0);

    // Async reset mid-alert, then re-entry at phase 0
    hold(3, 1'b1, 16'h4444, 2'd2, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_now("async_reset", 16'h9999, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_now("reset_held", 16'h9999, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{nums: 16'h4444, src: 2'd2, na: 1'b0});
    hold(7, 1'b1, 16'h4444, 2'd2, 1'b0);
    hold(1, 1'b1, 16'h9999, 2'd2, 1'b0);
    hold(2, 1'b0, 16'h0123, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
